// File: rtl/adc_sar_sequencer_if.sv
// Handshake/data bundle between the SAR sequencer and its user / analog front end.
// master: drives start and compare, observes the conversion outputs.
// slave:  the sequencer itself.
interface adc_sar_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             compare;
  logic [WIDTH-1:0] dac_code;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;

  modport master (
    output start, compare,
    input  dac_code, result, busy, done
  );

  modport slave (
    input  start, compare,
    output dac_code, result, busy, done
  );
endinterface

// File: rtl/adc_sar_sequencer.sv
// Successive-approximation sequencer for the PWM-DAC + comparator ADC.
// Tries one bit per step, MSB first. Each step waits SETTLE_CYCLES for
// the RC filter to settle, then spends one cycle sampling the comparator.
// Optional: define ADC_SAR_FREERUN_EN for continuous back-to-back
// conversions. In that build the start input is ignored.
module adc_sar_sequencer #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 2048
) (
  input  logic                CLOCK_50,
  input  logic                rst,
  adc_sar_sequencer_if.slave  bus
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0]    CNT_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [IW-1:0]    IDX_TOP  = IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB      = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, DECIDE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] trial_q;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    cnt_q;
  logic [IW-1:0]    idx_q;
  logic             busy_q;
  logic             done_q;

  logic             go;
  logic [WIDTH-1:0] bit_cur_d;
  logic [WIDTH-1:0] decided_d;
  logic [WIDTH-1:0] trial_d;

`ifdef ADC_SAR_FREERUN_EN
  assign go = 1'b1;
`else
  assign go = bus.start;
`endif

  // Trial update for the bit under test: keep or clear it, then arm the next lower bit.
  always_comb begin
    bit_cur_d = WIDTH'(1) << idx_q;
    decided_d = bus.compare ? trial_q : (trial_q & ~bit_cur_d);
    trial_d   = decided_d | (bit_cur_d >> 1);
  end

  // Sequencer FSM; every output is a register.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q  <= IDLE;
      trial_q  <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go) begin
            trial_q <= MSB;
            idx_q   <= IDX_TOP;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SETTLE;
          end else begin
            trial_q <= result_q;
          end
        end
        SETTLE: begin
          if (cnt_q == CNT_LAST) state_q <= DECIDE;
          else                   cnt_q   <= cnt_q + CW'(1);
        end
        DECIDE: begin
          if (idx_q != '0) begin
            trial_q <= trial_d;
            idx_q   <= idx_q - IW'(1);
            cnt_q   <= '0;
            state_q <= SETTLE;
          end else begin
            result_q <= decided_d;
            done_q   <= 1'b1;
`ifdef ADC_SAR_FREERUN_EN
            // Restart straight away so done keeps a fixed cadence.
            trial_q  <= MSB;
            idx_q    <= IDX_TOP;
            cnt_q    <= '0;
            state_q  <= SETTLE;
`else
            trial_q  <= decided_d;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.dac_code = trial_q;
  assign bus.result   = result_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: doc/adc_sar_sequencer.md
Name: adc_sar_sequencer

Overview:
Successive-approximation controller for the PWM-DAC + comparator ADC path. On request it drives trial codes into the PWM DAC one bit at a time, MSB first. For each bit it waits a programmable settle time for the RC-filtered PWM output to stabilise, then samples the comparator. It publishes the converted code with a start/busy/done handshake. It replaces a free-clocked binary search with a single-clock, CLOCK_50-domain sequencer.

Parameters:
WIDTH, 8, converter resolution in bits; sets the width of dac_code and result.
SETTLE_CYCLES, 2048, CLOCK_50 cycles spent waiting per bit before the comparator is sampled; minimum 1.

Ports:
CLOCK_50  input  1  system clock; all logic is on its rising edge.
rst  input  1  reset, synchronous, active-high.
start  input  1  conversion request; sampled only in IDLE.
compare  input  1  comparator; 1 when analog input >= dac_code.
dac_code  output  WIDTH  trial/hold code driven into the PWM DAC (registered).
result  output  WIDTH  last completed conversion (registered).
busy  output  1  high while a conversion is in progress.
done  output  1  single-cycle pulse when result has been updated.

Behaviour:
- Reset (rst=1 at an edge): state IDLE; dac_code=0, result=0, busy=0, done=0; settle counter and bit index cleared. Reset mid-conversion aborts it: no done pulse, result stays 0.
- States: IDLE, SETTLE, DECIDE.
- IDLE: dac_code holds result; busy=0.
  - On start=1: trial <= 1<<(WIDTH-1); bit index <= WIDTH-1; counter <= 0; go to SETTLE.
- SETTLE: counter increments each cycle. At the edge where counter==SETTLE_CYCLES-1, go to DECIDE. SETTLE lasts exactly SETTLE_CYCLES cycles.
- DECIDE (1 cycle): sample compare.
  - compare=1: keep the current bit.
  - compare=0: clear the current bit.
  - If bit index > 0: set the next lower bit, decrement the index, clear the counter, return to SETTLE.
  - If bit index == 0: result <= final trial, dac_code <= final trial, go to IDLE, and done=1 in the following cycle.
- dac_code always equals the current trial value while busy.
- busy = (state != IDLE) as a registered flag. It rises the cycle after start is accepted and falls in the same cycle done rises.
- Latency: with start sampled at edge t0, done is high during the cycle following edge t0 + WIDTH*(SETTLE_CYCLES+1). For WIDTH=8, SETTLE_CYCLES=4 that is 40 cycles.
- done is high for exactly 1 cycle per completed conversion.
- Simultaneous events:
  - start while busy: ignored, not queued.
  - start high in the cycle done is high (state IDLE): accepted, and a new conversion begins.
  - start held high continuously: back-to-back conversions.
  - rst overrides start.
- Arithmetic: the counter is clog2(SETTLE_CYCLES) bits (min 1). The bit index is clog2(WIDTH) bits and does not wrap below 0. Trial updates are bitwise set/clear only; no addition.
- compare is treated as synchronous to CLOCK_50. Any synchroniser belongs to the top level.

Optional Feature:
Macro ADC_SAR_FREERUN_EN.
- Defined: the sequencer converts continuously. The first conversion starts in the cycle after rst deasserts, and each subsequent conversion starts immediately on leaving DECIDE with bit index 0. The start input is ignored. done pulses every WIDTH*(SETTLE_CYCLES+1) cycles. busy stays 1 except during reset and the single IDLE pass-through cycle.
- Undefined: conversions occur only on start, as above.

Test Plan:
1. Reset: rst=1 for 2 cycles with start=1 -> dac_code=0, result=0, busy=0, done=0; no conversion begins while rst=1.
2. WIDTH=8, SETTLE_CYCLES=4, analog model 0xA5, 1-cycle start pulse -> busy=1 next cycle; dac_code steps 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5, each step held 5 cycles; done=1 exactly 40 cycles after the start edge; result=0xA5; busy=0 with done.
3. Boundaries: analog 0x00 -> result 0x00 (all bits cleared). Analog 0xFF -> result 0xFF, dac_code sequence 0x80,0xC0,...,0xFF. Analog 0x80 -> result 0x80.
4. Handshake: start pulses at cycles 10 and 25 after the first accepted start -> both ignored, exactly one done. start held high through done -> a second conversion begins with no idle gap; busy low only in the done cycle.
5. Abort: rst asserted 20 cycles into a conversion of 0x5A -> next cycle busy=0, dac_code=0, result=0; no done pulse. A fresh start then yields 0x5A.
6. With ADC_SAR_FREERUN_EN, analog stepping 0x33 then 0xCC -> done pulses every 40 cycles with start tied 0; results track 0x33 then 0xCC.
